logic_unit_arbiter: RTL
=======================

# logic_unit_arbiter

Shares one 64-bit bitwise logic unit (AND/OR/XOR gate banks) between two requesters in the ALU. Each requester issues an op and two operands over a valid/ready handshake. A round-robin arbiter grants one request per cycle into a registered one-entry result stage, and the result stage returns the result tagged with the requester id under its own valid/ready handshake.

## Interface
- WIDTH, 64, operand/result width in bits
- CNT_W, 16, width of the completed-operation counter
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_op  input  2  requester 0 operation code
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- rsp_valid  output  1  result register holds a valid result
- rsp_ready  input  1  consumer takes the result this cycle
- rsp_data  output  WIDTH  result
- rsp_id  output  1  requester that produced the result
- rsp_err  output  1  op code was illegal
- rsp_zero  output  1  rsp_data is all zeros
- op_count  output  CNT_W  completed responses, wraps modulo 2^CNT_W

## Operation
- Op codes:
  - 2'b00 = AND, result a&b
  - 2'b01 = OR, result a|b
  - 2'b10 = XOR, result a^b
  - 2'b11 = illegal: rsp_data = 0, rsp_err = 1, rsp_zero = 1
- Result-stage states:
  - EMPTY: rsp_valid = 0
  - FULL: rsp_valid = 1
- can_accept = (state == EMPTY) | (rsp_valid & rsp_ready).
- Arbitration:
  - Round-robin pointer prio, reset value 0.
  - If only one reqN_valid is high, that requester wins.
  - If both are high, requester prio wins.
  - reqN_ready = can_accept & winner == N.
  - reqN_ready may depend combinationally on reqN_valid.
- On accept, at the rising edge:
  - rsp_data, rsp_id, rsp_err and rsp_zero load from the winner.
  - State goes to FULL.
  - prio = ~winner.
- prio is updated only on a grant. With no grants it holds.
- No accept and rsp_valid & rsp_ready: state goes to EMPTY. The data registers hold their last values.
- op_count increments on each edge where rsp_valid & rsp_ready.
- Requester rule: once reqN_valid is high, the requester keeps it high with stable op/a/b until reqN_ready.
- Output stability: while rsp_valid & !rsp_ready, all rsp_* outputs stay stable.
- Reset mid-operation:
  - Any pending result is discarded.
  - All outputs return to their reset values immediately.
  - No response is produced for the discarded result.

## Timing
- Reset values:
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0, rsp_zero = 0
  - op_count = 0, prio = 0, state = EMPTY
  - req0_ready and req1_ready are 0 while rst_n is low.
- Latency: a request accepted at edge N gives rsp_valid = 1 in the cycle after edge N (1 cycle).
- Throughput: 1 result/cycle while rsp_ready = 1. A FULL stage that is drained and refilled on the same edge causes no bubble.
- Backpressure: with rsp_ready = 0 and state FULL, both reqN_ready are 0.
- Fairness: with both requesters valid continuously and rsp_ready = 1, grants alternate 0,1,0,1…. No requester waits more than one grant.
- Counter wrap: op_count goes 2^CNT_W−1 → 0 with no flag.

## Structure
- Package logic_unit_pkg holds:
  - op-code constants OP_AND, OP_OR, OP_XOR, OP_ILL
  - the EMPTY/FULL state encoding
- Sub-module logic_op_mux:
  - Instantiates the existing and_64bit, or_64bit and xor_64bit blocks on the granted operands.
  - Selects the result by op and produces err and zero.
  - Purely combinational.
- Top level holds arbiter, prio, result register, state and counter.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n = 0 mid-cycle, then release; drive no requests.
  - Response: every output reads its reset value. With no requests, rsp_valid stays 0 indefinitely.
- Single op per code:
  - Stimulus: requester 0 sends a = 64'hF0F0_F0F0_F0F0_F0F0, b = 64'hFF00_FF00_FF00_FF00 with ops 00, 01, 10.
  - Response: rsp_data = 64'hF000_F000_F000_F000, then 64'hFFF0_FFF0_FFF0_FFF0, then 64'h0FF0_0FF0_0FF0_0FF0. rsp_id = 0 and latency is 1 cycle for each.
- Illegal op and zero flag:
  - Stimulus 1: requester 1 sends op 11 with a = b = all ones.
  - Response 1: rsp_data = 0, rsp_err = 1, rsp_zero = 1, rsp_id = 1.
  - Stimulus 2: AND of 64'b1<<5 with 0.
  - Response 2: rsp_zero = 1, rsp_err = 0.
- Contention/fairness:
  - Stimulus: both requesters valid for 8 cycles with rsp_ready = 1.
  - Response: rsp_id sequence is 0,1,0,1,0,1,0,1 and op_count = 8.
- Backpressure:
  - Stimulus: hold rsp_ready = 0 for 5 cycles with the stage FULL.
  - Response: rsp_* are stable and both ready signals are 0. On rsp_ready = 1, the next result follows on the next cycle with no loss or duplication.
- Reset mid-operation and wrap:
  - Stimulus 1: assert rst_n with the stage FULL.
  - Response 1: rsp_valid drops immediately.
  - Stimulus 2: with CNT_W = 4, complete 17 ops.
  - Response 2: op_count = 1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter.
//   - Op-code constants for the bitwise logic unit.
//   - Result-stage state encoding.
//   - Round-robin winner helper used by the top-level arbiter.
package logic_unit_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } rs_state_e;

  // Lone requester always wins; on contention the priority pointer decides.
  // With no requester valid the result is 0, which only affects ready, never a grant.
  function automatic logic rr_winner(logic v0, logic v1, logic prio);
    if (v0 && v1) begin
      return prio;
    end
    return v1;
  endfunction

endpackage

// File: rtl/and_64bit.sv
// Bitwise AND gate bank.
// Ports:
//   a_i, b_i : operands
//   y_o      : a_i & b_i
module and_64bit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = a_i & b_i;

endmodule

// File: rtl/logic_op_mux.sv
// Combinational logic unit: drives the AND/OR/XOR gate banks with the granted
// operands and selects the result by op code.
// Ports:
//   op_i    : operation code (AND/OR/XOR/illegal)
//   a_i,b_i : granted operands
//   data_o  : selected result, zero for the illegal code
//   err_o   : op code was illegal
//   zero_o  : data_o is all zeros
module logic_op_mux
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] or_y;
  logic [WIDTH-1:0] xor_y;

  and_64bit #(.WIDTH(WIDTH)) u_and (
    .a_i (a_i),
    .b_i (b_i),
    .y_o (and_y)
  );

  or_64bit #(.WIDTH(WIDTH)) u_or (
    .a_i (a_i),
    .b_i (b_i),
    .y_o (or_y)
  );

  xor_64bit #(.WIDTH(WIDTH)) u_xor (
    .a_i (a_i),
    .b_i (b_i),
    .y_o (xor_y)
  );

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    unique case (op_i)
      OP_AND: data_o = and_y;
      OP_OR:  data_o = or_y;
      OP_XOR: data_o = xor_y;
      OP_ILL: begin
        data_o = '0;
        err_o  = 1'b1;
      end
      default: begin
        data_o = '0;
        err_o  = 1'b1;
      end
    endcase
    zero_o = (data_o == '0);
  end

endmodule

// File: rtl/or_64bit.sv
// Bitwise OR gate bank.
// Ports:
//   a_i, b_i : operands
//   y_o      : a_i | b_i
module or_64bit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = a_i | b_i;

endmodule

// File: rtl/xor_64bit.sv
// Bitwise XOR gate bank.
// Ports:
//   a_i, b_i : operands
//   y_o      : a_i ^ b_i
module xor_64bit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 64-bit bitwise logic
// unit, with a registered one-entry result stage and a completion counter.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   reqN_valid/ready          : requester N handshake (N = 0, 1)
//   reqN_op, reqN_a, reqN_b   : requester N op code and operands
//   rsp_valid/ready           : result handshake
//   rsp_data, rsp_id          : result and the requester that produced it
//   rsp_err, rsp_zero         : illegal op code / result is all zeros
//   op_count                  : completed responses, wraps silently
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  rs_state_e        state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             can_accept;
  logic             winner;
  logic             grant;
  logic             drain;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] mux_data;
  logic             mux_err;
  logic             mux_zero;

  assign rsp_valid = (state_q == StFull);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;
  assign rsp_zero  = zero_q;
  assign op_count  = cnt_q;

  // A full stage being drained this cycle can be refilled on the same edge.
  assign drain      = rsp_valid & rsp_ready;
  assign can_accept = (state_q == StEmpty) | drain;
  assign winner     = rr_winner(req0_valid, req1_valid, prio_q);
  assign grant      = can_accept & (req0_valid | req1_valid);

  // Gated by rst_n so no handshake can complete while reset is held.
  assign req0_ready = rst_n & can_accept & ~winner;
  assign req1_ready = rst_n & can_accept & winner;

  assign sel_op = winner ? req1_op : req0_op;
  assign sel_a  = winner ? req1_a  : req0_a;
  assign sel_b  = winner ? req1_b  : req0_b;

  logic_op_mux #(.WIDTH(WIDTH)) u_op_mux (
    .op_i   (sel_op),
    .a_i    (sel_a),
    .b_i    (sel_b),
    .data_o (mux_data),
    .err_o  (mux_err),
    .zero_o (mux_zero)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    data_d  = data_q;
    id_d    = id_q;
    err_d   = err_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;

    if (drain) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (grant) begin
      state_d = StFull;
      prio_d  = ~winner;
      data_d  = mux_data;
      id_d    = winner;
      err_d   = mux_err;
      zero_d  = mux_zero;
    end else if (drain) begin
      // Data registers keep their last values when the stage empties.
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      prio_q  <= 1'b0;
      data_q  <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
